// File: rtl/adc_stream_decoder_if.sv
// Stream bundle for the ADC word decoder: tagged input stream and decoded sample stream.
// The decoder uses the slave view; the producer/consumer side uses the master view.
interface adc_stream_decoder_if;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/adc_stream_decoder.sv
// Decodes the tagged ADC capture stream into sign-extended A/B sample beats with TLAST,
// plus per-burst statistics and sticky protocol-error flags.
module adc_stream_decoder #(
    parameter int TS_WIDTH  = 60,
    parameter int LEN_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    adc_stream_decoder_if.slave  axis,
    input  logic                 clear_stats,
    output logic                 burst_done,
    output logic [TS_WIDTH-1:0]  burst_ts,
    output logic [LEN_WIDTH-1:0] burst_len,
    output logic [15:0]          bursts_count,
    output logic [3:0]           err_flags
);
    typedef enum logic [1:0] {IDLE, WAIT_HIGH, BURST} state_t;

    localparam logic [1:0] TAG_TS_LOW  = 2'b00;
    localparam logic [1:0] TAG_TS_HIGH = 2'b01;
    localparam logic [1:0] TAG_DATA    = 2'b10;
    localparam logic [1:0] TAG_END     = 2'b11;

    state_t               state;
    logic [29:0]          ts_low;
    logic [LEN_WIDTH-1:0] len;
    logic                 pend_valid;
    logic [31:0]          pend_data;
    logic                 out_valid;
    logic [31:0]          out_data;
    logic                 out_last;

    logic        ready;
    logic        accept;
    logic [1:0]  tag;
    logic [29:0] payload;
    logic [31:0] sample;

    logic       emit;
    logic       emit_last;
    logic       close;
    logic [3:0] err_set;

    assign tag     = axis.s_axis_tdata[31:30];
    assign payload = axis.s_axis_tdata[29:0];
    assign sample  = {payload[29], payload[29:15], payload[14], payload[14:0]};

    // The output register is the only backpressure point; an accepted word emits at most one beat.
    assign ready  = !out_valid || axis.m_axis_tready;
    assign accept = axis.s_axis_tvalid && ready;

    assign axis.s_axis_tready = ready;
    assign axis.m_axis_tvalid = out_valid;
    assign axis.m_axis_tdata  = out_data;
    assign axis.m_axis_tlast  = out_last;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        emit      = 1'b0;
        emit_last = 1'b0;
        close     = 1'b0;
        err_set   = 4'b0000;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (tag == TAG_TS_HIGH) err_set[1] = 1'b1;
                    else if (tag[1])        err_set[0] = 1'b1;
                end
                WAIT_HIGH: begin
                    if (tag != TAG_TS_HIGH) err_set[1] = 1'b1;
                end
                BURST: begin
                    case (tag)
                        TAG_DATA: emit = pend_valid;
                        TAG_END, TAG_TS_LOW: begin
                            emit       = pend_valid;
                            emit_last  = 1'b1;
                            close      = 1'b1;
                            err_set[3] = (len == '0);
                            err_set[2] = (tag == TAG_TS_LOW);
                        end
                        default: err_set[1] = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= IDLE;
            ts_low       <= '0;
            len          <= '0;
            pend_valid   <= 1'b0;
            pend_data    <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            burst_done   <= 1'b0;
            burst_ts     <= '0;
            burst_len    <= '0;
            bursts_count <= '0;
            err_flags    <= '0;
        end else begin
            burst_done <= close;
            // A new error in the same cycle as clear_stats survives the clear.
            err_flags  <= (clear_stats ? 4'b0000 : err_flags) | err_set;
            if (clear_stats)
                bursts_count <= {15'd0, close};
            else if (close)
                bursts_count <= bursts_count + 16'd1;

            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= pend_data;
                out_last  <= emit_last;
            end else if (axis.m_axis_tready) begin
                out_valid <= 1'b0;
            end

            if (close) begin
                pend_valid <= 1'b0;
                burst_len  <= len;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (tag == TAG_TS_LOW) begin
                            ts_low <= payload;
                            state  <= WAIT_HIGH;
                        end
                    end
                    WAIT_HIGH: begin
                        case (tag)
                            TAG_TS_LOW: ts_low <= payload;
                            TAG_TS_HIGH: begin
                                burst_ts <= TS_WIDTH'({payload, ts_low});
                                len      <= '0;
                                state    <= BURST;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                    BURST: begin
                        case (tag)
                            TAG_DATA: begin
                                pend_data  <= sample;
                                pend_valid <= 1'b1;
                                if (len != '1) len <= len + LEN_WIDTH'(1);
                            end
                            TAG_END: state <= IDLE;
                            TAG_TS_LOW: begin
                                ts_low <= payload;
                                state  <= WAIT_HIGH;
                            end
                            default: ;
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_stream_decoder.sv
// Self-checking bench for adc_stream_decoder: directed scenarios plus a randomized stream,
// scored against a burst-level reference model that builds the expected beat list per burst.
module tb_adc_stream_decoder;
    localparam int TS_W  = 60;
    localparam int LEN_W = 4;
    localparam int LEN_MAX = (1 << LEN_W) - 1;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic             clear_stats = 1'b0;
    logic             burst_done;
    logic [TS_W-1:0]  burst_ts;
    logic [LEN_W-1:0] burst_len;
    logic [15:0]      bursts_count;
    logic [3:0]       err_flags;

    adc_stream_decoder_if axis();

    adc_stream_decoder #(.TS_WIDTH(TS_W), .LEN_WIDTH(LEN_W)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .axis         (axis),
        .clear_stats  (clear_stats),
        .burst_done   (burst_done),
        .burst_ts     (burst_ts),
        .burst_len    (burst_len),
        .bursts_count (bursts_count),
        .err_flags    (err_flags)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model state: burst-level view of the stream.
    bit           have_low = 0;
    bit           in_burst = 0;
    logic [29:0]  mdl_low = '0;
    logic [31:0]  samples[$];
    logic [32:0]  exp_out[$];
    logic [32:0]  got[$];
    logic [3:0]   exp_err = '0;
    int           exp_count = 0;
    int           exp_len = 0;
    logic [59:0]  exp_ts = '0;
    int           exp_done = 0;
    int           done_seen = 0;

    // 0: always ready, 1: stalled, 2: random ready
    int           rmode = 0;
    bit           hold_v = 0;
    logic [32:0]  hold_beat = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext_pair(input logic [29:0] p);
        int a;
        int b;
        a = int'(p[29:15]);
        b = int'(p[14:0]);
        if (a >= 16384) a -= 32768;
        if (b >= 16384) b -= 32768;
        return {a[15:0], b[15:0]};
    endfunction

    function automatic logic [31:0] dw(input int a, input int b);
        return {2'b10, a[14:0], b[14:0]};
    endfunction

    function automatic logic [31:0] tw(input logic [1:0] tg, input int p);
        return {tg, p[29:0]};
    endfunction

    task automatic model_close();
        int n;
        n = samples.size();
        for (int i = 0; i < n; i++) exp_out.push_back({i == n - 1, samples[i]});
        if (n == 0) exp_err |= 4'b1000;
        exp_len   = (n > LEN_MAX) ? LEN_MAX : n;
        exp_count = (exp_count + 1) & 16'hFFFF;
        exp_done++;
        samples.delete();
    endtask

    task automatic model_word(input logic [31:0] w, input bit clr);
        logic [1:0]  tg;
        logic [29:0] p;
        tg = w[31:30];
        p  = w[29:0];
        if (clr) begin
            exp_err   = '0;
            exp_count = 0;
        end
        if (in_burst) begin
            case (tg)
                2'b10: samples.push_back(sext_pair(p));
                2'b11: begin model_close(); in_burst = 0; end
                2'b00: begin
                    exp_err |= 4'b0100;
                    model_close();
                    in_burst = 0;
                    have_low = 1;
                    mdl_low  = p;
                end
                default: exp_err |= 4'b0010;
            endcase
        end else if (have_low) begin
            if (tg == 2'b01) begin
                exp_ts   = {p, mdl_low};
                in_burst = 1;
                have_low = 0;
                samples.delete();
            end else if (tg == 2'b00) begin
                exp_err |= 4'b0010;
                mdl_low  = p;
            end else begin
                exp_err |= 4'b0010;
                have_low = 0;
            end
        end else begin
            if (tg == 2'b00) begin
                mdl_low  = p;
                have_low = 1;
            end else if (tg == 2'b01) exp_err |= 4'b0010;
            else                      exp_err |= 4'b0001;
        end
    endtask

    task automatic send(input logic [31:0] w, input bit clr = 0);
        int n;
        n = 0;
        @(negedge aclk);
        axis.s_axis_tvalid = 1'b1;
        axis.s_axis_tdata  = w;
        clear_stats        = clr;
        while (!axis.s_axis_tready && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 300) check("accept_timeout", 64'(n), 64'd0);
        @(posedge aclk);
        #1;
        axis.s_axis_tvalid = 1'b0;
        clear_stats        = 1'b0;
        model_word(w, clr);
    endtask

    task automatic do_clear();
        @(negedge aclk);
        clear_stats = 1'b1;
        @(posedge aclk);
        #1;
        clear_stats = 1'b0;
        exp_err   = '0;
        exp_count = 0;
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #2 areset = 1'b1;
        @(negedge aclk);
        check("rst_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
        check("rst_tdata",  64'(axis.m_axis_tdata),  64'd0);
        check("rst_tlast",  64'(axis.m_axis_tlast),  64'd0);
        check("rst_done",   64'(burst_done),         64'd0);
        check("rst_stats",  {burst_ts[31:0], 12'd0, burst_len, bursts_count}, 64'd0);
        check("rst_err",    64'(err_flags),          64'd0);
        @(posedge aclk);
        #2 areset = 1'b0;
        have_low  = 0;
        in_burst  = 0;
        samples.delete();
        exp_err   = '0;
        exp_count = 0;
        exp_len   = 0;
        exp_ts    = '0;
    endtask

    task automatic drain();
        rmode = 0;
        repeat (20) @(negedge aclk);
    endtask

    task automatic compare();
        int n;
        check("beat_count", 64'(got.size()), 64'(exp_out.size()));
        n = (got.size() < exp_out.size()) ? got.size() : exp_out.size();
        for (int i = 0; i < n; i++) check("beat", 64'(got[i]), 64'(exp_out[i]));
        check("err_flags",    64'(err_flags),    64'(exp_err));
        check("bursts_count", 64'(bursts_count), 64'(exp_count));
        check("burst_len",    64'(burst_len),    64'(exp_len));
        check("burst_ts",     64'(burst_ts),     64'(exp_ts));
        check("done_pulses",  64'(done_seen),    64'(exp_done));
        got.delete();
        exp_out.delete();
    endtask

    always @(posedge aclk) begin
        #1;
        case (rmode)
            0:       axis.m_axis_tready = 1'b1;
            1:       axis.m_axis_tready = 1'b0;
            default: axis.m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: collects beats, checks stability under backpressure and stats on burst_done.
    always @(negedge aclk) begin
        if (areset) begin
            hold_v = 0;
        end else begin
            if (hold_v)
                check("stall_hold", 64'({axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tdata}),
                      64'({1'b1, hold_beat}));
            if (axis.m_axis_tvalid && axis.m_axis_tready)
                got.push_back({axis.m_axis_tlast, axis.m_axis_tdata});
            hold_v    = axis.m_axis_tvalid && !axis.m_axis_tready;
            hold_beat = {axis.m_axis_tlast, axis.m_axis_tdata};
            if (burst_done) begin
                done_seen++;
                check("done_len",   64'(burst_len),    64'(exp_len));
                check("done_count", 64'(bursts_count), 64'(exp_count));
            end
        end
    end

    initial begin
        logic [1:0] tg;
        int r;
        axis.s_axis_tvalid = 1'b0;
        axis.s_axis_tdata  = '0;
        axis.m_axis_tready = 1'b1;
        do_reset();

        // Basic burst
        send(tw(2'b00, 5));
        send(tw(2'b01, 0));
        send(dw(123, 555));
        send(dw(-1, 1));
        send(dw(16'h4000, 16'h3FFF));
        send(tw(2'b11, 0));
        drain();
        check("basic_beat1", 64'(got[0]), 64'({1'b0, 32'h007B_022B}));
        check("basic_beat2", 64'(got[1]), 64'({1'b0, 32'hFFFF_0001}));
        check("basic_beat3", 64'(got[2]), 64'({1'b1, 32'hC000_3FFF}));
        compare();

        // Same burst with a 10-cycle downstream stall
        rmode = 1;
        send(tw(2'b00, 5));
        send(tw(2'b01, 0));
        send(dw(123, 555));
        send(dw(-1, 1));
        repeat (10) begin
            @(negedge aclk);
            check("stall_s_ready", 64'(axis.s_axis_tready), 64'd0);
            check("stall_m_valid", 64'(axis.m_axis_tvalid), 64'd1);
        end
        rmode = 0;
        send(dw(16'h4000, 16'h3FFF));
        send(tw(2'b11, 0));
        drain();
        compare();

        // Orphan data then ts_high in IDLE
        do_clear();
        send(dw(7, 8));
        send(tw(2'b01, 9));
        drain();
        check("orphan_err", 64'(err_flags), 64'd3);
        compare();
        do_clear();
        @(negedge aclk);
        check("cleared_err", 64'(err_flags), 64'(exp_err));

        // Truncation by a new header
        send(tw(2'b00, 9));
        send(tw(2'b01, 0));
        send(dw(10, 20));
        send(dw(-30, 40));
        send(tw(2'b00, 77));
        send(tw(2'b01, 3));
        send(dw(5, -6));
        send(tw(2'b11, 0));
        drain();
        check("trunc_ts", 64'(burst_ts), (64'd3 << 30) | 64'd77);
        compare();

        // Empty burst
        do_clear();
        send(tw(2'b00, 1));
        send(tw(2'b01, 2));
        send(tw(2'b11, 0));
        drain();
        check("empty_len", 64'(burst_len), 64'd0);
        compare();

        // clear_stats coinciding with a close and with a new error
        send(tw(2'b00, 4));
        send(tw(2'b01, 4));
        send(dw(1, 1));
        send(tw(2'b11, 0), 1);
        @(negedge aclk);
        check("clr_close_count", 64'(bursts_count), 64'd1);
        send(tw(2'b01, 0), 1);
        drain();
        check("clr_err_wins", 64'(err_flags), 64'd2);
        compare();

        // Length counter saturation
        send(tw(2'b00, 11));
        send(tw(2'b01, 12));
        for (int i = 0; i < 20; i++) send(dw(int'($urandom), int'($urandom)));
        send(tw(2'b11, 0));
        drain();
        check("sat_len", 64'(burst_len), 64'(LEN_MAX));
        compare();

        // Reset in the middle of a burst, then a fresh burst
        send(tw(2'b00, 21));
        send(tw(2'b01, 22));
        send(dw(100, 200));
        do_reset();
        send(tw(2'b00, 31));
        send(tw(2'b01, 32));
        send(dw(-5, 5));
        send(dw(6, -6));
        send(tw(2'b11, 0));
        drain();
        compare();

        // Randomized stream with random downstream readiness
        rmode = 2;
        repeat (300) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       tg = 2'b00;
            else if (r < 12) tg = 2'b01;
            else if (r < 88) tg = 2'b10;
            else             tg = 2'b11;
            if (have_low && ($urandom_range(0, 3) != 0)) tg = 2'b01;
            send({tg, 30'($urandom)}, ($urandom_range(0, 63) == 0));
            if ($urandom_range(0, 3) == 0) rmode = 2;
        end
        if (in_burst) send(tw(2'b11, 0));
        drain();
        compare();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
